input_buffer_v2: RTL

- Parametrised input buffer for the EC accelerator datapath, sitting between the host write interface and the bit-matrix multiply units.
- Stores full-width input words in an internal FIFO of configurable depth.
- On a controller read request, pops one word and unpacks it into a registered NUM_UNITS x W array of PACKET_LENGTH-bit packets, with a valid pulse.
- Adds occupancy count, flush, and sticky overflow/underflow error flags.

---
 rtl/input_buffer_v2.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/input_buffer_v2.sv
// Input buffer: FIFO of full-width words, popped into a registered packet array two cycles after a read.
// Optional almost-full output enabled by defining INBUF_ALMOST_FULL_EN.
module input_buffer_v2 #(
    parameter int NUM_UNITS     = 4,
    parameter int W             = 4,
    parameter int PACKET_LENGTH = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 12,
    localparam int DATA_W       = NUM_UNITS * W * PACKET_LENGTH,
    localparam int CNT_W        = $clog2(DEPTH + 1),
    localparam int PTR_W        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              inbuf_wr_req,
    input  logic [DATA_W-1:0] inbuf_wr_data,
    output logic              inbuf_full,
    input  logic              cntl_inbuf_rd_req,
    output logic              inbuf_empty,
    output logic [CNT_W-1:0]  inbuf_count,
    output logic              inbuf_dout_val,
    output logic [DATA_W-1:0] inbuf_dout,
    output logic              inbuf_err_ovf,
    output logic              inbuf_err_udf
`ifdef INBUF_ALMOST_FULL_EN
    ,
    output logic              inbuf_afull
`endif
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_THRESH > DEPTH) begin : g_bad_param
        $error("input_buffer_v2: DEPTH must be a power of two >= 2 and AFULL_THRESH <= DEPTH");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_mem_q;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_rd_stg1;
    logic              r_dout_val;
    logic [DATA_W-1:0] r_dout;
    logic              r_err_ovf;
    logic              r_err_udf;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [DATA_W-1:0] w_unpacked;

    // Flags come from registered count only, so requests never loop back into full/empty.
    assign w_full   = (r_count == DEPTH_C);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = inbuf_wr_req && !w_full;
    assign w_rd_acc = cntl_inbuf_rd_req && !w_empty;
    assign w_wr_en  = rst_n && !flush && w_wr_acc;
    assign w_rd_en  = rst_n && !flush && w_rd_acc;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_unpacked = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            for (int j = 0; j < W; j++) begin
                w_unpacked[(u*W+j)*PACKET_LENGTH +: PACKET_LENGTH] =
                    r_mem_q[(u*W+j)*PACKET_LENGTH +: PACKET_LENGTH];
            end
        end
    end

    // Storage and the memory output register carry no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= inbuf_wr_data;
        end
        if (w_rd_en) begin
            r_mem_q <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_stg1  <= 1'b0;
            r_dout_val <= 1'b0;
            r_dout     <= '0;
            r_err_ovf  <= 1'b0;
            r_err_udf  <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_stg1  <= 1'b0;
            r_dout_val <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_nxt;
            r_rd_stg1  <= w_rd_acc;
            r_dout_val <= r_rd_stg1;
            if (r_rd_stg1) begin
                r_dout <= w_unpacked;
            end
            if (inbuf_wr_req && w_full) begin
                r_err_ovf <= 1'b1;
            end
            if (cntl_inbuf_rd_req && w_empty) begin
                r_err_udf <= 1'b1;
            end
        end
    end

`ifdef INBUF_ALMOST_FULL_EN
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_THRESH);
    logic r_afull;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_afull <= 1'b0;
        end else begin
            r_afull <= (w_count_nxt >= AFULL_C);
        end
    end

    assign inbuf_afull = r_afull;
`endif

    assign inbuf_full     = w_full;
    assign inbuf_empty    = w_empty;
    assign inbuf_count    = r_count;
    assign inbuf_dout_val = r_dout_val;
    assign inbuf_dout     = r_dout;
    assign inbuf_err_ovf  = r_err_ovf;
    assign inbuf_err_udf  = r_err_udf;

endmodule
